reg_checkpoint_monitor: RTL and testbench
=========================================

# reg_checkpoint_monitor

Synthesizable, parametrised run-time checker for the pipelined processor. It replaces ad-hoc bench checks of the form "at cycle N, register R must hold V, then redirect PC". A table of up to NUM_CHECKS checkpoints is loaded and a run is started. The block counts cycles, reads the register file through a spare read port at each checkpoint, compares against the expected value, optionally redirects the PC, and reports pass/fail counts and the first failing checkpoint.

## Interface
- DATA_W, 32, register/expected data width
- REG_ADDR_W, 5, register file address width
- PC_W, 32, PC redirect width
- CYCLE_W, 32, cycle counter width
- NUM_CHECKS, 8, checkpoint table depth (>=1); IDX_W = clog2(NUM_CHECKS), minimum 1

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  write checkpoint cfg_idx (accepted only when busy=0)
- cfg_idx  in  IDX_W  table index
- cfg_cycle  in  CYCLE_W  target cycle
- cfg_reg  in  REG_ADDR_W  register to check
- cfg_expect  in  DATA_W  expected value
- cfg_pc_en  in  1  issue PC redirect after this check
- cfg_pc  in  PC_W  redirect target
- num_checks  in  IDX_W+1  active entries 0..NUM_CHECKS, sampled on start
- start  in  1  begin run (ignored while busy=1)
- rf_raddr  out  REG_ADDR_W  register file read address
- rf_rdata  in  DATA_W  combinational read data for rf_raddr
- pc_load  out  1  one-cycle PC redirect strobe
- pc_value  out  PC_W  redirect target, valid with pc_load
- busy  out  1  run in progress
- done  out  1  run complete; level, held
- pass  out  1  done and fail_count==0; held
- pass_count  out  IDX_W+1  checks matched
- fail_count  out  IDX_W+1  checks mismatched
- first_fail_idx  out  IDX_W+1  index of first mismatch; all-ones = none
- cycle  out  CYCLE_W  current run cycle

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE. busy, done, pass, pc_load, pass_count, fail_count, cycle, rf_raddr and pc_value are 0. first_fail_idx is all-ones. Table contents are not reset.
- IDLE/DONE and start=1:
  - clear counts and done.
  - first_fail_idx is set to all-ones.
  - latch num_checks, set idx=0 and cycle=1.
  - go to RUN; busy=1.
  - If num_checks==0, go directly to DONE with pass=1.
- RUN, every cycle:
  - rf_raddr = table[idx].reg (combinational from idx).
  - cycle increments, saturating at all-ones.
  - If cycle >= table[idx].cycle, the check fires:
    - compare rf_rdata against expect;
    - increment pass_count or fail_count;
    - on the first mismatch, record first_fail_idx = idx;
    - if pc_en, register pc_load=1 and pc_value=pc for the next cycle;
    - advance idx.
  - At most one check fires per cycle. A duplicate or already-passed target fires on the next free cycle. Entries are evaluated in index order, not sorted.
  - After the last active entry fires: go to DONE, busy=0, done=1, pass = (fail_count==0) including this final check.
- cfg_we while busy=1 is ignored. Table writes in IDLE/DONE take effect at the edge.
- rst mid-run: abort immediately to reset values; no pc_load is issued.
- Cycle counter saturation: entries whose target is beyond the saturated value fire at saturation, since the >= rule holds.

## Timing
- start sampled at edge E0. After E0: cycle=1, RUN.
- A check with target T fires in the cycle where cycle==T (rf_raddr and rf_rdata are same-cycle). Counters update at the next edge.
- pc_load is high for exactly one cycle, the cycle after the firing cycle.
- done/pass rise at the edge ending the last firing cycle. Latency from start to done = last target + 1 edges when no collisions occur.
- rf_raddr is combinational from the registered idx; the RF read is zero-wait.

## Test plan
- Two checks, cycle 6 reg 23 expect 20 pc_en pc 220, then cycle 12 reg 24 expect 35; RF model holds 20/35 -> pc_load pulse value 220 in cycle 7, done after cycle 12, pass=1, pass_count=2, first_fail_idx all-ones.
- Same table, RF reg 24 = 34 -> fail_count=1, pass=0, first_fail_idx=1, done still asserted.
- Three entries all target cycle 5 -> fire at cycles 5, 6, 7; rf_raddr steps through the three regs; pass_count=3.
- num_checks=0 and start -> done=1, pass=1 one edge later; no pc_load.
- rst asserted at cycle 4 of a run -> next cycle all outputs at reset values. A new start then runs correctly with the preserved table.
- cfg_we during RUN overwriting entry 1 -> ignored; the original expected value is used. start pulsed during RUN -> ignored.

Source files
------------

// File: rtl/reg_checkpoint_monitor_if.sv
// rtl/reg_checkpoint_monitor_if.sv - checkpoint table load, run control, RF read port and PC redirect bundle
interface reg_checkpoint_monitor_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int PC_W       = 32,
    parameter int CYCLE_W    = 32,
    parameter int NUM_CHECKS = 8
);
    localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;

    logic                  cfg_we;
    logic [IDX_W-1:0]      cfg_idx;
    logic [CYCLE_W-1:0]    cfg_cycle;
    logic [REG_ADDR_W-1:0] cfg_reg;
    logic [DATA_W-1:0]     cfg_expect;
    logic                  cfg_pc_en;
    logic [PC_W-1:0]       cfg_pc;
    logic [IDX_W:0]        num_checks;
    logic                  start;
    logic [REG_ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0]     rf_rdata;
    logic                  pc_load;
    logic [PC_W-1:0]       pc_value;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [IDX_W:0]        pass_count;
    logic [IDX_W:0]        fail_count;
    logic [IDX_W:0]        first_fail_idx;
    logic [CYCLE_W-1:0]    cycle;

    modport master (
        output cfg_we, cfg_idx, cfg_cycle, cfg_reg, cfg_expect, cfg_pc_en, cfg_pc,
        output num_checks, start, rf_rdata,
        input  rf_raddr, pc_load, pc_value, busy, done, pass,
        input  pass_count, fail_count, first_fail_idx, cycle
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_cycle, cfg_reg, cfg_expect, cfg_pc_en, cfg_pc,
        input  num_checks, start, rf_rdata,
        output rf_raddr, pc_load, pc_value, busy, done, pass,
        output pass_count, fail_count, first_fail_idx, cycle
    );
endinterface

// File: rtl/reg_checkpoint_monitor.sv
// rtl/reg_checkpoint_monitor.sv - cycle-indexed register checkpoint checker with optional PC redirect
module reg_checkpoint_monitor #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int PC_W       = 32,
    parameter int CYCLE_W    = 32,
    parameter int NUM_CHECKS = 8
) (
    input logic                    clk,
    input logic                    rst,
    reg_checkpoint_monitor_if.slave bus
);
    localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0]   MAX_CHECKS = CNT_W'(NUM_CHECKS);
    localparam logic [CNT_W-1:0]   NO_FAIL    = '1;
    localparam logic [CYCLE_W-1:0] CYCLE_MAX  = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic [CYCLE_W-1:0]    tbl_cycle  [NUM_CHECKS];
    logic [REG_ADDR_W-1:0] tbl_reg    [NUM_CHECKS];
    logic [DATA_W-1:0]     tbl_expect [NUM_CHECKS];
    logic                  tbl_pc_en  [NUM_CHECKS];
    logic [PC_W-1:0]       tbl_pc     [NUM_CHECKS];

    logic [IDX_W-1:0]      idx;
    logic [CNT_W-1:0]      n_active;
    logic [CYCLE_W-1:0]    cycle_q;
    logic                  busy_q, done_q, pass_q, pc_load_q;
    logic [PC_W-1:0]       pc_value_q;
    logic [CNT_W-1:0]      pass_count_q, fail_count_q, first_fail_q;

    logic                  fire, match, last, cfg_ok;
    logic [CNT_W-1:0]      idx_inc;

    assign idx_inc = {1'b0, idx} + CNT_W'(1);
    assign fire    = (state == RUN) && (cycle_q >= tbl_cycle[idx]);
    assign match   = (bus.rf_rdata == tbl_expect[idx]);
    assign last    = (idx_inc == n_active);
    assign cfg_ok  = ({1'b0, bus.cfg_idx} < MAX_CHECKS);

    assign bus.rf_raddr       = (state == RUN) ? tbl_reg[idx] : '0;
    assign bus.pc_load        = pc_load_q;
    assign bus.pc_value       = pc_value_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.pass_count     = pass_count_q;
    assign bus.fail_count     = fail_count_q;
    assign bus.first_fail_idx = first_fail_q;
    assign bus.cycle          = cycle_q;

    // Table is deliberately not reset so a run can be repeated after an abort.
    always_ff @(posedge clk) begin
        if (bus.cfg_we && !busy_q && cfg_ok) begin
            tbl_cycle[bus.cfg_idx]  <= bus.cfg_cycle;
            tbl_reg[bus.cfg_idx]    <= bus.cfg_reg;
            tbl_expect[bus.cfg_idx] <= bus.cfg_expect;
            tbl_pc_en[bus.cfg_idx]  <= bus.cfg_pc_en;
            tbl_pc[bus.cfg_idx]     <= bus.cfg_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            pc_load_q    <= 1'b0;
            pc_value_q   <= '0;
            pass_count_q <= '0;
            fail_count_q <= '0;
            first_fail_q <= NO_FAIL;
            cycle_q      <= '0;
            idx          <= '0;
            n_active     <= '0;
        end else begin
            pc_load_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        pass_count_q <= '0;
                        fail_count_q <= '0;
                        first_fail_q <= NO_FAIL;
                        idx          <= '0;
                        cycle_q      <= CYCLE_W'(1);
                        n_active     <= (bus.num_checks > MAX_CHECKS) ? MAX_CHECKS : bus.num_checks;
                        if (bus.num_checks == '0) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                            done_q <= 1'b0;
                            pass_q <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (cycle_q != CYCLE_MAX) begin
                        cycle_q <= cycle_q + CYCLE_W'(1);
                    end
                    // One entry per cycle, strictly in index order; late entries catch up one per cycle.
                    if (fire) begin
                        if (match) begin
                            pass_count_q <= pass_count_q + CNT_W'(1);
                        end else begin
                            fail_count_q <= fail_count_q + CNT_W'(1);
                            if (fail_count_q == '0) begin
                                first_fail_q <= {1'b0, idx};
                            end
                        end
                        if (tbl_pc_en[idx]) begin
                            pc_load_q  <= 1'b1;
                            pc_value_q <= tbl_pc[idx];
                        end
                        idx <= idx + IDX_W'(1);
                        if (last) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= (fail_count_q == '0) && match;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_checkpoint_monitor.sv
// tb/tb_reg_checkpoint_monitor.sv - randomized and directed checks of reg_checkpoint_monitor against a schedule model
module tb_reg_checkpoint_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_checkpoint_monitor_if #(.DATA_W(32), .REG_ADDR_W(5), .PC_W(32), .CYCLE_W(32), .NUM_CHECKS(8)) bus();

    reg_checkpoint_monitor #(.DATA_W(32), .REG_ADDR_W(5), .PC_W(32), .CYCLE_W(32), .NUM_CHECKS(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] rf [32];
    assign bus.rf_rdata = rf[bus.rf_raddr];

    int          m_tgt  [8];
    logic [4:0]  m_reg  [8];
    logic [31:0] m_exp  [8];
    bit          m_pcen [8];
    logic [31:0] m_pc   [8];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".busy"}, bus.busy, 0);
        check({tag, ".done"}, bus.done, 0);
        check({tag, ".pass"}, bus.pass, 0);
        check({tag, ".pc_load"}, bus.pc_load, 0);
        check({tag, ".pc_value"}, bus.pc_value, 0);
        check({tag, ".pass_count"}, bus.pass_count, 0);
        check({tag, ".fail_count"}, bus.fail_count, 0);
        check({tag, ".first_fail"}, bus.first_fail_idx, 15);
        check({tag, ".cycle"}, bus.cycle, 0);
        check({tag, ".rf_raddr"}, bus.rf_raddr, 0);
    endtask

    task automatic set_entry(input int i, input int tgt, input int r, input logic [31:0] e,
                             input bit pe, input logic [31:0] pc);
        m_tgt[i] = tgt; m_reg[i] = 5'(r); m_exp[i] = e; m_pcen[i] = pe; m_pc[i] = pc;
        bus.cfg_we = 1'b1; bus.cfg_idx = 3'(i); bus.cfg_cycle = 32'(tgt); bus.cfg_reg = 5'(r);
        bus.cfg_expect = e; bus.cfg_pc_en = pe; bus.cfg_pc = pc;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    // mode 0: plain run, 1: ignored cfg_we/start noise during RUN, 2: reset at run cycle 4
    task automatic run_check(input int n, input int mode);
        int fire_at [8];
        int prev, last, e_fail, e_ff, k, p_sofar, f_sofar;
        bit pl;
        logic [31:0] pv;
        prev = 0; e_fail = 0; e_ff = 15;
        for (int i = 0; i < n; i++) begin
            fire_at[i] = (m_tgt[i] > prev) ? m_tgt[i] : prev + 1;
            prev = fire_at[i];
            if (rf[m_reg[i]] != m_exp[i]) begin
                e_fail++;
                if (e_ff == 15) e_ff = i;
            end
        end
        last = prev;
        bus.num_checks = 4'(n);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= last + 1; c++) begin
            if (c > 1) @(negedge clk);
            pl = 0; pv = '0; p_sofar = 0; f_sofar = 0; k = -1;
            for (int i = 0; i < n; i++) begin
                if (fire_at[i] == c - 1 && m_pcen[i]) begin pl = 1; pv = m_pc[i]; end
                if (fire_at[i] < c) begin
                    if (rf[m_reg[i]] == m_exp[i]) p_sofar++; else f_sofar++;
                end else if (k < 0) begin
                    k = i;
                end
            end
            if (mode == 2 && c == 4) begin
                rst = 1'b1;
                @(negedge clk);
                check_reset_state("abort");
                rst = 1'b0;
                return;
            end
            check("pc_load", bus.pc_load, pl);
            if (pl) check("pc_value", bus.pc_value, pv);
            check("pass_count", bus.pass_count, p_sofar);
            check("fail_count", bus.fail_count, f_sofar);
            if (c <= last) begin
                check("busy", bus.busy, 1);
                check("done_early", bus.done, 0);
                check("cycle", bus.cycle, c);
                check("rf_raddr", bus.rf_raddr, m_reg[k]);
                if (mode == 1) begin
                    bus.start      = ($urandom_range(0, 2) == 0);
                    bus.cfg_we     = $urandom_range(0, 1);
                    bus.cfg_idx    = 3'($urandom_range(0, 7));
                    bus.cfg_cycle  = $urandom_range(0, 3);
                    bus.cfg_reg    = 5'($urandom);
                    bus.cfg_expect = $urandom;
                    bus.cfg_pc_en  = 1'b1;
                    bus.cfg_pc     = $urandom;
                end
            end else begin
                bus.start = 1'b0;
                bus.cfg_we = 1'b0;
                check("busy_end", bus.busy, 0);
                check("done", bus.done, 1);
                check("pass", bus.pass, (e_fail == 0));
                check("first_fail", bus.first_fail_idx, e_ff);
                check("rf_raddr_idle", bus.rf_raddr, 0);
            end
        end
    endtask

    initial begin
        bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_cycle = '0; bus.cfg_reg = '0;
        bus.cfg_expect = '0; bus.cfg_pc_en = 0; bus.cfg_pc = '0; bus.num_checks = '0; bus.start = 0;
        for (int r = 0; r < 32; r++) rf[r] = $urandom;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        rf[23] = 20; rf[24] = 35;
        set_entry(0, 6, 23, 20, 1, 220);
        set_entry(1, 12, 24, 35, 0, 0);
        run_check(2, 0);
        rf[24] = 34;
        run_check(2, 0);
        rf[24] = 35;
        run_check(2, 2);
        run_check(2, 0);
        run_check(2, 1);

        rf[1] = 11; rf[2] = 22; rf[3] = 33;
        set_entry(0, 5, 1, 11, 0, 0);
        set_entry(1, 5, 2, 22, 1, 32'h400);
        set_entry(2, 5, 3, 33, 0, 0);
        run_check(3, 0);
        run_check(0, 0);

        for (int t = 0; t < 40; t++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int r = 0; r < 32; r++) rf[r] = $urandom_range(0, 7);
            for (int i = 0; i < n; i++) begin
                int r;
                r = $urandom_range(0, 31);
                set_entry(i, $urandom_range(0, 20), r,
                          ($urandom_range(0, 3) != 0) ? rf[r] : 32'($urandom_range(0, 7)),
                          $urandom_range(0, 1), $urandom);
            end
            run_check(n, (t % 4 == 3) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
